// File: rtl/pipeline_3_memory_pkg.sv
// Shared definitions for pipeline stage 3 (memory): control-word bit
// positions, the ALU opcode that enables overflow, and the memory FSM states.
package pipeline_3_memory_pkg;

   localparam int CTRL_W      = 22;
   localparam int C_ALUOP_LO  = 6;
   localparam int C_ALUOP_HI  = 7;
   localparam int C_MEM_RD    = 13;
   localparam int C_MEM_WR    = 14;
   localparam int C_SET_FLAGS = 15;
   localparam int C_REG_WR    = 16;
   localparam int C_VALID     = 21;

   localparam logic [1:0] ALUOP_SUB = 2'b01;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_flag_unit.sv
// Combinational {Z,N,V} from the ALU result and the sign bits of both
// operands. Overflow is only meaningful for subtraction; other ops give V=0.
module pipeline_flag_unit #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] result_i,
   input  logic          rn_hi_i,
   input  logic          rm_hi_i,
   input  logic          is_sub_i,
   output logic [2:0]    flags_o
);

   logic z, n, v;

   // Sub overflows when operand signs differ and the result sign differs from A.
   always_comb begin
      z       = ~|result_i;
      n       = result_i[DW-1];
      v       = is_sub_i & (rn_hi_i != rm_hi_i) & (result_i[DW-1] != rn_hi_i);
      flags_o = {z, n, v};
   end

endmodule

// File: rtl/vDFF.sv
// Plain register with synchronous active-low clear; enables are built as a
// hold mux in front of d_i by the instantiating module.
module vDFF #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   // Clear on rst=0, otherwise load the next value every edge.
   always_ff @(posedge clk) begin
      if (!rst) q_o <= '0;
      else      q_o <= d_i;
   end

endmodule

// File: rtl/pipeline_3_memory.sv
// Pipeline stage 3: latches the execute outputs, drives a variable-latency
// data-memory port, computes status flags and registers the writeback value.
// While an access is outstanding the stage holds and stalls upstream.
module pipeline_3_memory
   import pipeline_3_memory_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] control_in,
   input  logic [2:0]        num_Rd_in,
   input  logic [DW-1:0]     data_Rd_in,
   input  logic [DW-1:0]     result_in,
   input  logic              highbit_shifted_Rm_in,
   input  logic              highbit_data_Rn_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   input  logic              mem_ready,
   output logic              stall_out,
   output logic [CTRL_W-1:0] control_out,
   output logic [2:0]        num_Rd_out,
   output logic [DW-1:0]     wb_data_out,
   output logic [2:0]        flags_out
);

   localparam int SW = CTRL_W + 3 + 2*DW + 2;
   localparam int OW = CTRL_W + 3 + DW;

   // ---------------- stage register ----------------
   logic [SW-1:0]     stage_d, stage_q;
   logic [CTRL_W-1:0] ctl;
   logic [2:0]        rd;
   logic [DW-1:0]     rd_data, result;
   logic              rn_hi, rm_hi;

   assign stage_d = stall_out ? stage_q
                              : {control_in, num_Rd_in, data_Rd_in, result_in,
                                 highbit_data_Rn_in, highbit_shifted_Rm_in};

   vDFF #(.N(SW)) u_stage (.clk(clk), .rst(rst), .d_i(stage_d), .q_o(stage_q));

   assign {ctl, rd, rd_data, result, rn_hi, rm_hi} = stage_q;

   logic valid, is_rd, is_wr, mem_op, complete;
   assign valid    = ctl[C_VALID];
   assign is_rd    = ctl[C_MEM_RD];
   assign is_wr    = ctl[C_MEM_WR];
   assign mem_op   = valid & (is_rd | is_wr);
   assign complete = valid & (~mem_op | mem_ready);

   // ---------------- memory FSM ----------------
   state_t state_q, state_d;

   // State register; reset abandons any outstanding access.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Issue in IDLE, hold the request in WAIT until mem_ready completes it.
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      stall_out = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               mem_req = 1'b1;
               if (!mem_ready) begin
                  stall_out = 1'b1;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            mem_req = mem_op;
            if (!mem_op || mem_ready) state_d   = S_IDLE;
            else                      stall_out = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address/data come straight from the held stage register, so they stay
   // stable for the whole wait. A combined RD+WR is treated as a store.
   assign mem_we    = mem_req & is_wr;
   assign mem_addr  = mem_req ? result[AW-1:0] : '0;
   assign mem_wdata = mem_req ? rd_data : '0;

   // ---------------- writeback register ----------------
   logic [DW-1:0] wb_data;
   logic [OW-1:0] out_d, out_q;

   assign wb_data = (is_rd & ~is_wr) ? mem_rdata : result;
   assign out_d   = complete ? {ctl, rd, wb_data} : '0;

   vDFF #(.N(OW)) u_out (.clk(clk), .rst(rst), .d_i(out_d), .q_o(out_q));

   assign {control_out, num_Rd_out, wb_data_out} = out_q;

   // ---------------- flags ----------------
   logic [2:0] flags_calc, flags_d, flags_q;

   pipeline_flag_unit #(.DW(DW)) u_flags (
      .result_i (result),
      .rn_hi_i  (rn_hi),
      .rm_hi_i  (rm_hi),
      .is_sub_i (ctl[C_ALUOP_HI:C_ALUOP_LO] == ALUOP_SUB),
      .flags_o  (flags_calc)
   );

   assign flags_d = (complete & ctl[C_SET_FLAGS]) ? flags_calc : flags_q;

   vDFF #(.N(3)) u_flagreg (.clk(clk), .rst(rst), .d_i(flags_d), .q_o(flags_q));

   assign flags_out = flags_q;

endmodule

// File: tb/tb_pipeline_3_memory.sv
// Bench for pipeline_3_memory: directed scenarios with inline checks, plus a
// scoreboard of expected writeback records compared as they leave the stage.
module tb_pipeline_3_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic [21:0] control_in;
   logic [2:0]  num_Rd_in;
   logic [15:0] data_Rd_in, result_in;
   logic        highbit_shifted_Rm_in, highbit_data_Rn_in;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready, stall_out;
   logic [21:0] control_out;
   logic [2:0]  num_Rd_out;
   logic [15:0] wb_data_out;
   logic [2:0]  flags_out;

   pipeline_3_memory dut (
      .clk(clk), .rst(rst),
      .control_in(control_in), .num_Rd_in(num_Rd_in), .data_Rd_in(data_Rd_in),
      .result_in(result_in), .highbit_shifted_Rm_in(highbit_shifted_Rm_in),
      .highbit_data_Rn_in(highbit_data_Rn_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_out(stall_out),
      .control_out(control_out), .num_Rd_out(num_Rd_out), .wb_data_out(wb_data_out),
      .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [21:0] ctl;
      logic [2:0]  rd;
      logic [15:0] wb;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   bit   mon_en = 1'b0;

   // Control word: VALID=21, REG_WR=16, SET_FLAGS=15, MEM_WR=14, MEM_RD=13, ALUop=[7:6];
   // low bits carry a tag so pass-through of the whole word is visible.
   function automatic logic [21:0] mk(bit v, bit rw, bit sf, bit mrd, bit mwr, logic [1:0] op);
      logic [21:0] c;
      c       = 22'h000005;
      c[21]   = v;
      c[16]   = rw;
      c[15]   = sf;
      c[14]   = mwr;
      c[13]   = mrd;
      c[7:6]  = op;
      return c;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [21:0] c, logic [2:0] r, logic [15:0] d, logic [15:0] res,
                        bit rn, bit rm);
      control_in            = c;
      num_Rd_in             = r;
      data_Rd_in            = d;
      result_in             = res;
      highbit_data_Rn_in    = rn;
      highbit_shifted_Rm_in = rm;
   endtask

   task automatic bubble;
      drive(22'h0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   // Scoreboard: every non-bubble writeback must match the oldest expectation.
   always @(negedge clk) begin
      if (mon_en && rst && control_out != 22'h0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got ctl=%h rd=%0d wb=%h", control_out, num_Rd_out, wb_data_out);
         end else begin
            mon_e = sb.pop_front();
            if ({control_out, num_Rd_out, wb_data_out} !== mon_e) begin
               bad++;
               $display("FAIL sb_out got ctl=%h rd=%0d wb=%h exp ctl=%h rd=%0d wb=%h",
                        control_out, num_Rd_out, wb_data_out, mon_e.ctl, mon_e.rd, mon_e.wb);
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(22'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
         mem_ready = 1'($urandom);
         mem_rdata = 16'($urandom);
         tick();
      end
      total++;
      if ({mem_req, mem_we, stall_out} !== 3'b000) begin
         bad++; $display("FAIL reset_mem_ctl got %b exp 000", {mem_req, mem_we, stall_out});
      end
      total++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
         bad++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata});
      end
      total++;
      if ({control_out, num_Rd_out, wb_data_out} !== 41'h0) begin
         bad++; $display("FAIL reset_wb got ctl=%h rd=%0d wb=%h exp 0", control_out, num_Rd_out, wb_data_out);
      end
      total++;
      if (flags_out !== 3'b000) begin
         bad++; $display("FAIL reset_flags got %b exp 000", flags_out);
      end
      bubble();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
      rst = 1'b1;
      tick();
      mon_en = 1'b1;
   endtask

   task automatic test_alu;
      logic [21:0] c;
      c = mk(1, 1, 0, 0, 0, 2'b00);
      drive(c, 3'd3, 16'h5555, 16'h1234, 0, 0);
      sb.push_back({c, 3'd3, 16'h1234});
      tick();
      total++;
      if ({stall_out, mem_req} !== 2'b00) begin
         bad++; $display("FAIL alu_nostall got stall=%b req=%b exp 0 0", stall_out, mem_req);
      end
      bubble();
      tick();
      total++;
      if (wb_data_out !== 16'h1234 || stall_out !== 1'b0) begin
         bad++; $display("FAIL alu_wb got wb=%h stall=%b exp 1234 0", wb_data_out, stall_out);
      end
   endtask

   task automatic test_load_wait;
      logic [21:0] c;
      c = mk(1, 1, 0, 1, 0, 2'b00);
      drive(c, 3'd5, 16'h7777, 16'h0040, 0, 0);
      sb.push_back({c, 3'd5, 16'hBEEF});
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      tick();
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({stall_out, mem_req, mem_we} !== 3'b110 || mem_addr !== 16'h0040) begin
            bad++; $display("FAIL load_wait%0d got stall=%b req=%b we=%b addr=%h exp 1 1 0 0040",
                            i, stall_out, mem_req, mem_we, mem_addr);
         end
         total++;
         if (control_out !== 22'h0) begin
            bad++; $display("FAIL load_bubble%0d got ctl=%h exp 0", i, control_out);
         end
         if (i != 2) tick();
      end
      mem_ready = 1'b1;
      mem_rdata = 16'hBEEF;
      #1;
      total++;
      if (stall_out !== 1'b0) begin
         bad++; $display("FAIL load_release got stall=%b exp 0", stall_out);
      end
      bubble();
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
      total++;
      if (wb_data_out !== 16'hBEEF || num_Rd_out !== 3'd5) begin
         bad++; $display("FAIL load_wb got wb=%h rd=%0d exp BEEF 5", wb_data_out, num_Rd_out);
      end
   endtask

   task automatic test_store;
      logic [21:0] c;
      c = mk(1, 0, 0, 0, 1, 2'b00);
      drive(c, 3'd2, 16'h00AA, 16'h0080, 0, 0);
      sb.push_back({c, 3'd2, 16'h0080});
      mem_ready = 1'b1;
      mem_rdata = 16'hCCCC;
      tick();
      total++;
      if ({mem_req, mem_we, stall_out} !== 3'b110 || mem_wdata !== 16'h00AA || mem_addr !== 16'h0080) begin
         bad++; $display("FAIL store_port got req=%b we=%b stall=%b wdata=%h addr=%h exp 1 1 0 00AA 0080",
                         mem_req, mem_we, stall_out, mem_wdata, mem_addr);
      end
      bubble();
      tick();
      mem_ready = 1'b0;
   endtask

   task automatic test_rd_wr_both;
      logic [21:0] c;
      c = mk(1, 0, 0, 1, 1, 2'b00);
      drive(c, 3'd6, 16'h0101, 16'h0033, 0, 0);
      sb.push_back({c, 3'd6, 16'h0033});
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
      tick();
      total++;
      if (mem_we !== 1'b1) begin
         bad++; $display("FAIL rdwr_we got %b exp 1", mem_we);
      end
      bubble();
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
   endtask

   task automatic test_flags;
      logic [21:0] c;
      // SUB overflow: negative result from 0 - negative.
      c = mk(1, 1, 1, 0, 0, 2'b01);
      drive(c, 3'd1, 16'h0, 16'h8000, 0, 1);
      sb.push_back({c, 3'd1, 16'h8000});
      tick(); bubble(); tick();
      total++;
      if (flags_out !== 3'b011) begin
         bad++; $display("FAIL flags_sub got %b exp 011", flags_out);
      end
      c = mk(1, 1, 1, 0, 0, 2'b00);
      drive(c, 3'd1, 16'h0, 16'h0000, 0, 1);
      sb.push_back({c, 3'd1, 16'h0000});
      tick(); bubble(); tick();
      total++;
      if (flags_out !== 3'b100) begin
         bad++; $display("FAIL flags_zero got %b exp 100", flags_out);
      end
      c = mk(1, 1, 0, 0, 0, 2'b01);
      drive(c, 3'd4, 16'h0, 16'h8000, 0, 1);
      sb.push_back({c, 3'd4, 16'h8000});
      tick(); bubble(); tick();
      total++;
      if (flags_out !== 3'b100) begin
         bad++; $display("FAIL flags_hold got %b exp 100", flags_out);
      end
   endtask

   task automatic test_back_to_back;
      logic [21:0] c;
      c = mk(1, 1, 0, 1, 0, 2'b00);
      drive(c, 3'd1, 16'h0, 16'h0010, 0, 0);
      sb.push_back({c, 3'd1, 16'h1111});
      tick();
      mem_ready = 1'b1;
      mem_rdata = 16'h1111;
      drive(c, 3'd2, 16'h0, 16'h0020, 0, 0);
      sb.push_back({c, 3'd2, 16'h2222});
      tick();
      total++;
      if ({mem_req, stall_out} !== 2'b10 || mem_addr !== 16'h0020) begin
         bad++; $display("FAIL b2b_issue got req=%b stall=%b addr=%h exp 1 0 0020", mem_req, stall_out, mem_addr);
      end
      mem_rdata = 16'h2222;
      bubble();
      tick();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
      tick();
   endtask

   task automatic test_reset_mid_wait;
      logic [21:0] c;
      c = mk(1, 1, 0, 1, 0, 2'b00);
      drive(c, 3'd7, 16'h0, 16'h0099, 0, 0);
      mem_ready = 1'b0;
      tick();
      tick();
      total++;
      if (stall_out !== 1'b1) begin
         bad++; $display("FAIL rstwait_pre got stall=%b exp 1", stall_out);
      end
      rst = 1'b0;
      tick();
      total++;
      if ({mem_req, stall_out} !== 2'b00 || control_out !== 22'h0 || flags_out !== 3'b000) begin
         bad++; $display("FAIL rstwait_clear got req=%b stall=%b ctl=%h flags=%b exp 0 0 0 000",
                         mem_req, stall_out, control_out, flags_out);
      end
      rst = 1'b1;
      bubble();
      mem_ready = 1'b1;
      mem_rdata = 16'hFFFF;
      tick();
      mem_ready = 1'b0;
      total++;
      if ({mem_req, stall_out} !== 2'b00 || control_out !== 22'h0) begin
         bad++; $display("FAIL rstwait_late got req=%b stall=%b ctl=%h exp 0 0 0", mem_req, stall_out, control_out);
      end
      // Stage must be fully usable again.
      c = mk(1, 1, 0, 0, 0, 2'b10);
      drive(c, 3'd3, 16'h0, 16'h4321, 1, 0);
      sb.push_back({c, 3'd3, 16'h4321});
      tick(); bubble(); tick();
   endtask

   initial begin
      rst = 1'b0;
      bubble();
      mem_ready = 1'b0;
      mem_rdata = 16'h0;
      test_reset();
      test_alu();
      test_load_wait();
      test_store();
      test_rd_wr_both();
      test_flags();
      test_back_to_back();
      test_reset_mid_wait();
      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_drain got %0d pending exp 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
